// File: rtl/reg8_load_driver.sv
// reg8_load_driver: drives an 8-bit edge-triggered load register (D, EN_N, CLR_N, CK, Q)
// with cycle-counted setup, clock pulse and hold windows. It then samples Q and reports
// the readback value and a match flag on a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command; register pins parked
// SETUP | D/EN_N presented, waiting DSETUP cycles before the clock edge
// CKHI  | register clock high for one cycle
// HOLD  | clock low, D/EN_N still held for DHOLD cycles
// CLRP  | clear pulse, CLR_N low for DSETUP cycles
// WAIT  | pins released, waiting DCKQ cycles for Q to settle
// CHECK | readback captured, done pulse
`timescale 1ns/1ps
module reg8_load_driver #(
  parameter int DSETUP = 1,
  parameter int DHOLD  = 1,
  parameter int DCKQ   = 1
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       cmd_valid,
  input  logic       cmd_clr,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       done,
  output logic       match,
  output logic [7:0] rd_q,
  output logic [7:0] RD,
  output logic       REN_N,
  output logic       RCLR_N,
  output logic       RCK,
  input  logic [7:0] RQ
);

  localparam int MAXP = (DSETUP > DHOLD) ? ((DSETUP > DCKQ) ? DSETUP : DCKQ)
                                         : ((DHOLD > DCKQ) ? DHOLD : DCKQ);
  localparam int CW = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CKHI  = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_CHECK = 3'd5,
    S_CLRP  = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_load;
  logic            w_cnt_last;
  logic            w_accept;
  logic            r_cmd_clr;
  logic [7:0]      r_cmd_data;
  logic [7:0]      w_expected;

  logic            r_ready;
  logic            r_done;
  logic            r_match;
  logic [7:0]      r_rd_q;
  logic [7:0]      r_rd;
  logic            r_ren_n;
  logic            r_rclr_n;
  logic            r_rck;

  logic            w_ready;
  logic            w_done;
  logic [7:0]      w_rd;
  logic            w_ren_n;
  logic            w_rclr_n;
  logic            w_rck;
  logic            w_capture;

  assign w_cnt_last = (r_cnt == CW'(1));
  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_expected = r_cmd_clr ? 8'h00 : r_cmd_data;
  assign w_capture  = (r_state == S_WAIT) && (w_next == S_CHECK);

  // State register and shared down-counter, reloaded on every state change
  always_ff @(posedge CK) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= CW'(1);
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= w_cnt_load;
      end else if (r_cnt > CW'(1)) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Next-state decode and the counter value for the state being entered
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = cmd_clr ? S_CLRP : S_SETUP;
      S_SETUP: if (w_cnt_last) w_next = S_CKHI;
      S_CKHI:  w_next = S_HOLD;
      S_HOLD:  if (w_cnt_last) w_next = S_WAIT;
      S_CLRP:  if (w_cnt_last) w_next = S_WAIT;
      S_WAIT:  if (w_cnt_last) w_next = S_CHECK;
      S_CHECK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    case (w_next)
      S_SETUP: w_cnt_load = CW'(DSETUP);
      S_CLRP:  w_cnt_load = CW'(DSETUP);
      S_HOLD:  w_cnt_load = CW'(DHOLD);
      S_WAIT:  w_cnt_load = CW'(DCKQ);
      default: w_cnt_load = CW'(1);
    endcase
  end

  // Pin values decoded from the next state so every output comes straight off a flop
  always_comb begin
    w_ready  = (w_next == S_IDLE);
    w_done   = (w_next == S_CHECK);
    w_rck    = (w_next == S_CKHI);
    w_ren_n  = !((w_next == S_SETUP) || (w_next == S_CKHI) || (w_next == S_HOLD));
    w_rclr_n = (w_next != S_CLRP);
    w_rd     = r_rd;
    if (w_accept && !cmd_clr) begin
      w_rd = cmd_data;
    end
  end

  // Command latch: later changes on the command inputs are ignored
  always_ff @(posedge CK) begin
    if (CLR) begin
      r_cmd_clr  <= 1'b0;
      r_cmd_data <= 8'h00;
    end else if (w_accept) begin
      r_cmd_clr  <= cmd_clr;
      r_cmd_data <= cmd_data;
    end
  end

  // Output registers, including readback capture at the WAIT->CHECK edge
  always_ff @(posedge CK) begin
    if (CLR) begin
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_rck    <= 1'b0;
      r_ren_n  <= 1'b1;
      r_rclr_n <= 1'b1;
      r_rd     <= 8'h00;
      r_rd_q   <= 8'h00;
      r_match  <= 1'b0;
    end else begin
      r_ready  <= w_ready;
      r_done   <= w_done;
      r_rck    <= w_rck;
      r_ren_n  <= w_ren_n;
      r_rclr_n <= w_rclr_n;
      r_rd     <= w_rd;
      if (w_capture) begin
        r_rd_q <= RQ;
        // An unknown RQ fails the if-condition and reads as a mismatch
        if (RQ == w_expected) begin
          r_match <= 1'b1;
        end else begin
          r_match <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready = r_ready;
  assign done      = r_done;
  assign match     = r_match;
  assign rd_q      = r_rd_q;
  assign RD        = r_rd;
  assign REN_N     = r_ren_n;
  assign RCLR_N    = r_rclr_n;
  assign RCK       = r_rck;

endmodule

// File: tb/tb_reg8_load_driver.sv
// Testbench for reg8_load_driver: a driver pushes expected readback/timing into a queue,
// a negedge monitor measures pin activity per operation and checks each done against it.
`timescale 1ns/1ps
module tb_reg8_load_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_clr = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, done, match, REN_N, RCLR_N, RCK;
  logic [7:0] rd_q, RD;
  logic [7:0] model_q = 8'h00;
  logic       stuck = 1'b0;

  reg8_load_driver dut (
    .CK(clk), .CLR(clr), .cmd_valid(cmd_valid), .cmd_clr(cmd_clr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .done(done), .match(match), .rd_q(rd_q),
    .RD(RD), .REN_N(REN_N), .RCLR_N(RCLR_N), .RCK(RCK), .RQ(model_q)
  );

  // behavioural model of the target register
  always @(posedge RCK or negedge RCLR_N) begin
    if (!RCLR_N) model_q <= 8'h00;
    else if (!REN_N && !stuck) model_q <= RD;
  end

  // second DUT with longer windows
  logic       clr2 = 1'b1;
  logic       valid2 = 1'b0;
  logic       ready2, done2, match2, REN_N2, RCLR_N2, RCK2;
  logic [7:0] rd_q2, RD2;
  logic [7:0] model2_q = 8'h00;

  reg8_load_driver #(.DSETUP(3), .DHOLD(2), .DCKQ(4)) dut2 (
    .CK(clk), .CLR(clr2), .cmd_valid(valid2), .cmd_clr(1'b0), .cmd_data(8'hC3),
    .cmd_ready(ready2), .done(done2), .match(match2), .rd_q(rd_q2),
    .RD(RD2), .REN_N(REN_N2), .RCLR_N(RCLR_N2), .RCK(RCK2), .RQ(model2_q)
  );

  always @(posedge RCK2 or negedge RCLR_N2) begin
    if (!RCLR_N2) model2_q <= 8'h00;
    else if (!REN_N2) model2_q <= RD2;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int rd; int m; int lat; int ren; int rck; int rck_at; int rclr;
  } exp_t;
  exp_t q_exp[$];

  // monitor for the default DUT
  int  acc, ren_cnt, rck_cnt, rck_at, rclr_cnt, viol;
  bit  busy = 0;
  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      busy = 0;
    end else if (cmd_valid && cmd_ready) begin
      busy = 1; acc = cyc; ren_cnt = 0; rck_cnt = 0; rck_at = 0; rclr_cnt = 0; viol = 0;
    end else if (busy) begin
      if (!REN_N) ren_cnt++;
      if (!RCLR_N) rclr_cnt++;
      if (RCK) begin
        if (rck_cnt == 0) rck_at = cyc - acc;
        rck_cnt++;
      end
      if (!REN_N && !RCLR_N) viol++;
      if (RCK && !RCLR_N) viol++;
    end
    if (done) begin
      if (q_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 rd_q=%0h expected no done", rd_q);
      end else begin
        e = q_exp.pop_front();
        chk("rd_q", int'(rd_q), e.rd);
        chk("match", int'(match), e.m);
        chk("latency", cyc - acc, e.lat);
        chk("ren_low_cycles", ren_cnt, e.ren);
        chk("rck_high_cycles", rck_cnt, e.rck);
        chk("rck_offset", rck_at, e.rck_at);
        chk("rclr_low_cycles", rclr_cnt, e.rclr);
        chk("pin_violations", viol, 0);
      end
      busy = 0;
    end
  end

  // monitor for the second DUT
  bit t6_stop = 0;
  int n_done2 = 0, rck2_cnt = 0, rdy_low2 = 0, last_done2 = 0;
  always @(negedge clk) begin
    if (!clr2 && !t6_stop) begin
      if (RCK2) rck2_cnt++;
      if (n_done2 > 0 && !ready2) rdy_low2++;
      if (done2) begin
        n_done2++;
        chk("t6_rd_q", int'(rd_q2), 8'hC3);
        chk("t6_match", int'(match2), 1);
        if (n_done2 > 1) chk("t6_period", cyc - last_done2, 12);
        last_done2 = cyc;
        if (n_done2 == 6) t6_stop = 1;
      end
    end
  end

  task automatic send(input bit c, input logic [7:0] d, input exp_t e);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got cmd_ready=0 expected 1");
    end
    q_exp.push_back(e);
    cmd_clr = c; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = 8'hEE; cmd_clr = ~c;
    n = 0;
    while (q_exp.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (q_exp.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  initial begin
    exp_t e;
    int n;
    // T1: reset, with a command offered during reset
    cmd_valid = 1'b1; cmd_data = 8'hAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready_during_clr", int'(cmd_ready), 1);
    clr = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_RD", int'(RD), 0);
    chk("rst_REN_N", int'(REN_N), 1);
    chk("rst_RCLR_N", int'(RCLR_N), 1);
    chk("rst_RCK", int'(RCK), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_rd_q", int'(rd_q), 0);

    // T2: load 42
    e = '{rd: 8'h42, m: 1, lat: 5, ren: 3, rck: 1, rck_at: 2, rclr: 0};
    send(1'b0, 8'h42, e);
    // T3: load 99 with model stuck at 42
    stuck = 1'b1;
    e = '{rd: 8'h42, m: 0, lat: 5, ren: 3, rck: 1, rck_at: 2, rclr: 0};
    send(1'b0, 8'h99, e);
    // T4: clear
    e = '{rd: 8'h00, m: 1, lat: 3, ren: 0, rck: 0, rck_at: 0, rclr: 1};
    send(1'b1, 8'h77, e);
    stuck = 1'b0;

    // T5: abort a load of 5A in HOLD
    cmd_clr = 1'b0; cmd_data = 8'h5A; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_ckhi_rck", int'(RCK), 1);
    @(posedge clk); #1;
    chk("t5_hold_ren_n", int'(REN_N), 0);
    chk("t5_hold_rck", int'(RCK), 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t5_abort_rck", int'(RCK), 0);
    chk("t5_abort_ren_n", int'(REN_N), 1);
    chk("t5_abort_done", int'(done), 0);
    chk("t5_abort_ready", int'(cmd_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    e = '{rd: 8'h0F, m: 1, lat: 5, ren: 3, rck: 1, rck_at: 2, rclr: 0};
    send(1'b0, 8'h0F, e);

    // T6: longer windows, command held continuously
    valid2 = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_in_clr", int'(ready2), 1);
    clr2 = 1'b0;
    n = 0;
    while (!t6_stop && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("t6_done_count", n_done2, 6);
    chk("t6_rck_count", rck2_cnt, 6);
    chk("t6_ready_low", rdy_low2, 55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
